// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
package seg7_scan_pkg;

    `include "seg7_defs.vh"

    // Which digit is currently being driven.
    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } digit_t;

    // Active-low anode pattern that enables exactly one digit.
    function automatic logic [1:0] an_select(input digit_t d);
        return (d == DIG1) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Straight font lookup.
    always_comb begin
        pattern = HEX_FONT[nibble];
    end

endmodule

// File: rtl/seg7_defs.vh
// Shared seven-segment constants: hex font (active-low, {g,f,e,d,c,b,a})
// and the all-off patterns for segments and anodes.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

localparam logic [6:0] SEG_OFF = 7'h7F;
localparam logic [1:0] AN_OFF  = 2'b11;

localparam logic [6:0] HEX_FONT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
};

`endif

// File: rtl/seg7_scan.sv
// Two-digit multiplexed hex display driver with registered pin outputs.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       load,
    input  logic       en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_IDLE = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic [1:0]     AN_IDLE  = AN_ACTIVE_LOW ? AN_OFF : ~AN_OFF;
    localparam logic           DP_IDLE  = SEG_ACTIVE_LOW;

    logic [7:0]    disp_reg;
    logic [CW-1:0] cnt_reg;
    digit_t        state_reg;
    logic [6:0]    seg_reg;
    logic [1:0]    an_reg;
    logic          dp_reg;

    logic [3:0]    nibble;
    logic [6:0]    font_pat;
    logic [6:0]    seg_next;
    logic [1:0]    an_next;
    logic          cnt_wrap;

    assign cnt_wrap = (cnt_reg == CNT_LAST);

    // Pick the nibble belonging to the digit currently selected.
    always_comb begin
        nibble = (state_reg == DIG1) ? disp_reg[7:4] : disp_reg[3:0];
    end

    hex7_decode u_decode (
        .nibble  (nibble),
        .pattern (font_pat)
    );

    // Apply pin polarity; enable gates only the anodes, segments stay driven.
    always_comb begin
        seg_next = SEG_ACTIVE_LOW ? font_pat : ~font_pat;
        an_next  = AN_IDLE;
        if (en) begin
            an_next = AN_ACTIVE_LOW ? an_select(state_reg) : ~an_select(state_reg);
        end
    end

    // Display byte capture and free-running refresh counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_reg <= 8'h00;
            cnt_reg  <= '0;
        end else begin
            if (load) begin
                disp_reg <= in;
            end
            cnt_reg <= cnt_wrap ? '0 : cnt_reg + 1'b1;
        end
    end

    // Digit FSM plus output registers, outputs built from pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= DIG0;
            seg_reg   <= SEG_IDLE;
            an_reg    <= AN_IDLE;
            dp_reg    <= DP_IDLE;
        end else begin
            if (cnt_wrap) begin
                state_reg <= (state_reg == DIG0) ? DIG1 : DIG0;
            end
            seg_reg <= seg_next;
            an_reg  <= an_next;
            dp_reg  <= DP_IDLE;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;
    assign dp  = dp_reg;

endmodule
